receiver: RTL and testbench

RECEIVER -- requirements
Module: receiver

---
 rtl/receiver_pkg.sv | 15 +
 rtl/receiver_sync2.sv | 24 ++
 rtl/receiver.sv | 125 ++++++++++++
 tb/tb_receiver.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/receiver_pkg.sv
// Shared serial-frame definitions for the sender and receiver sides of the link.
// FSM state encoding, data width and total frame length (start + data + stop).
package receiver_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 1 + DATA_BITS + 1;

endpackage

// File: rtl/receiver_sync2.sv
// Two-flop synchronizer for one asynchronous bit; two clk latency, no backpressure.
// Both flops reset to RST_VAL so an idle-high line reads high straight out of reset.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/receiver.sv
// Serial byte receiver (start 0, 8 data LSB first, stop 1), oversampled CLKS_PER_BIT times.
// Result pulses 3 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT clk after the start edge; no backpressure.
module receiver
  import receiver_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic [7:0] rx_data,
  output logic       rx_status,
  output logic       frame_err,
  output logic       rx_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT) + 1;
  localparam int BIT_W = $clog2(DATA_BITS) + 1;
  localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  logic                 din_s;
  rx_state_t            state, state_nxt;
  logic [CNT_W-1:0]     clk_cnt, clk_cnt_nxt;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_nxt;
  logic [DATA_BITS-1:0] shreg, shreg_nxt;
  logic [7:0]           rx_data_nxt;
  logic                 rx_status_nxt, frame_err_nxt;
  logic                 armed, armed_nxt;

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (din),
    .q   (din_s)
  );

  assign rx_busy = (state != IDLE);

  // armed records that the line has been seen high since the last start or
  // framing error, so a held-low break never retriggers and a start edge
  // coinciding with STOP->IDLE is still caught one cycle later.
  always_comb begin
    state_nxt     = state;
    clk_cnt_nxt   = clk_cnt;
    bit_cnt_nxt   = bit_cnt;
    shreg_nxt     = shreg;
    rx_data_nxt   = rx_data;
    rx_status_nxt = 1'b0;
    frame_err_nxt = 1'b0;
    armed_nxt     = armed | din_s;
    case (state)
      IDLE: begin
        if (armed && !din_s) begin
          state_nxt   = START;
          clk_cnt_nxt = '0;
          bit_cnt_nxt = '0;
          armed_nxt   = 1'b0;
        end
      end
      START: begin
        if (clk_cnt == HALF_CNT) begin
          clk_cnt_nxt = '0;
          state_nxt   = din_s ? IDLE : DATA;
        end else begin
          clk_cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end
      DATA: begin
        if (clk_cnt == FULL_CNT) begin
          clk_cnt_nxt = '0;
          shreg_nxt   = {din_s, shreg[DATA_BITS-1:1]};
          if (bit_cnt == LAST_BIT) begin
            bit_cnt_nxt = '0;
            state_nxt   = STOP;
          end else begin
            bit_cnt_nxt = bit_cnt + BIT_W'(1);
          end
        end else begin
          clk_cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end
      STOP: begin
        if (clk_cnt == FULL_CNT) begin
          clk_cnt_nxt = '0;
          state_nxt   = IDLE;
          if (din_s) begin
            rx_data_nxt   = shreg;
            rx_status_nxt = 1'b1;
          end else begin
            frame_err_nxt = 1'b1;
            armed_nxt     = 1'b0;
          end
        end else begin
          clk_cnt_nxt = clk_cnt + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx_data   <= 8'h00;
      rx_status <= 1'b0;
      frame_err <= 1'b0;
      armed     <= 1'b0;
    end else begin
      state     <= state_nxt;
      clk_cnt   <= clk_cnt_nxt;
      bit_cnt   <= bit_cnt_nxt;
      shreg     <= shreg_nxt;
      rx_data   <= rx_data_nxt;
      rx_status <= rx_status_nxt;
      frame_err <= frame_err_nxt;
      armed     <= armed_nxt;
    end
  end

endmodule

// File: tb/tb_receiver.sv
// Bench for receiver: serial driver, expected-pulse queue model and per-cycle compare.
`timescale 1ns/1ps
module tb_receiver;

  localparam int CPB = 16;
  localparam int LAT = 3 + CPB / 2 + 9 * CPB;
  localparam real BIT_NS = CPB * 10.0;

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic [7:0] rx_data;
  logic       rx_status;
  logic       frame_err;
  logic       rx_busy;

  receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .rx_data   (rx_data),
    .rx_status (rx_status),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] data;
    int         exp_cyc;
  } exp_t;

  exp_t       exp_q[$];
  int         rise_q[$];
  int         cyc = 0;
  int         n_vec = 0;
  int         n_mis = 0;
  int         n_status = 0;
  int         n_ferr = 0;
  logic [7:0] model_data = 8'h00;
  bit         prev_stat = 1'b0;
  bit         prev_ferr = 1'b0;

  always @(posedge clk) cyc++;

  task automatic chk(input bit ok, input string name, input int act, input int req);
    n_vec++;
    if (!ok) begin
      n_mis++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Frame driver: each bit lasts CPB clk periods adjusted by skew_ps.
  task automatic send_frame(input logic [7:0] d, input logic stop_v, input int skew_ps,
                            input bit expect_it, input bit check_lat);
    realtime bt;
    exp_t e;
    bt = BIT_NS + skew_ps / 1000.0;
    if (expect_it) begin
      e.is_err  = !stop_v;
      e.data    = d;
      e.exp_cyc = check_lat ? cyc + 1 + LAT : -1;
      exp_q.push_back(e);
    end
    din = 1'b0;
    #(bt);
    for (int i = 0; i < 8; i++) begin
      din = d[i];
      #(bt);
    end
    din = stop_v;
    #(bt);
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_data = 8'h00;
      prev_stat  = 1'b0;
      prev_ferr  = 1'b0;
      chk({rx_status, frame_err, rx_busy} == 3'b000, "reset_outputs",
          {rx_status, frame_err, rx_busy}, 0);
      chk(rx_data == 8'h00, "reset_rx_data", rx_data, 0);
    end else begin
      if (rx_status && frame_err) chk(1'b0, "both_pulses", 3, 0);
      if ((rx_status && prev_stat) || (frame_err && prev_ferr))
        chk(1'b0, "pulse_width", {rx_status, frame_err}, 0);
      if (rx_status || frame_err) begin
        if (rx_status) begin
          n_status++;
          rise_q.push_back(cyc);
        end
        if (frame_err) n_ferr++;
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_pulse", {rx_status, frame_err}, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk(rx_status == !e.is_err, "pulse_kind", {rx_status, frame_err},
              e.is_err ? 1 : 2);
          if (rx_status && !e.is_err) begin
            chk(rx_data == e.data, "rx_data_value", rx_data, e.data);
            model_data = e.data;
          end
          if (e.exp_cyc >= 0)
            chk((cyc - e.exp_cyc) >= -1 && (cyc - e.exp_cyc) <= 1, "latency", cyc, e.exp_cyc);
        end
      end
      chk(rx_data == model_data, "rx_data_hold", rx_data, model_data);
      prev_stat = rx_status;
      prev_ferr = frame_err;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_s, base_f, base_r, skew, gap;
    logic [7:0] d;

    rst = 1'b1;
    din = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk(rx_data == 8'h00, "post_reset_data", rx_data, 8'h00);
    chk(rx_busy == 1'b0, "post_reset_busy", rx_busy, 0);
    repeat (4) @(posedge clk);
    #1;

    // Single clean frame.
    send_frame(8'hA5, 1'b1, 0, 1'b1, 1'b1);
    #(2 * BIT_NS);
    @(negedge clk);
    chk(rx_data == 8'hA5, "a5_data", rx_data, 8'hA5);
    chk(rx_busy == 1'b0, "a5_busy_after", rx_busy, 0);
    chk(n_status == 1, "a5_status_count", n_status, 1);
    chk(n_ferr == 0, "a5_ferr_count", n_ferr, 0);

    // Short low glitch on an idle line.
    @(posedge clk);
    #1 din = 1'b0;
    repeat (4) @(posedge clk);
    #1 din = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk(rx_busy == 1'b0, "glitch_idle", rx_busy, 0);
    #(2 * BIT_NS);
    @(negedge clk);
    chk(n_status == 1 && n_ferr == 0, "glitch_no_pulse", n_status + n_ferr, 1);
    chk(rx_data == 8'hA5, "glitch_data", rx_data, 8'hA5);

    // Bad stop bit followed by a long break.
    @(posedge clk);
    #1;
    send_frame(8'h3C, 1'b0, 0, 1'b1, 1'b1);
    #(40 * BIT_NS);
    din = 1'b1;
    #(2 * BIT_NS);
    @(negedge clk);
    chk(n_ferr == 1, "break_ferr_count", n_ferr, 1);
    chk(rx_data == 8'hA5, "break_data_kept", rx_data, 8'hA5);
    chk(n_status == 1, "break_no_status", n_status, 1);

    // Back-to-back frames with no idle time.
    @(posedge clk);
    #1;
    base_s = n_status;
    base_r = rise_q.size();
    send_frame(8'h00, 1'b1, 0, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 0, 1'b1, 1'b1);
    send_frame(8'h55, 1'b1, 0, 1'b1, 1'b1);
    #(2 * BIT_NS);
    @(negedge clk);
    chk(n_status - base_s == 3, "b2b_count", n_status - base_s, 3);
    chk(rx_data == 8'h55, "b2b_last_data", rx_data, 8'h55);
    if (rise_q.size() >= base_r + 3) begin
      chk(rise_q[base_r + 1] - rise_q[base_r] == 10 * CPB, "b2b_spacing_1",
          rise_q[base_r + 1] - rise_q[base_r], 10 * CPB);
      chk(rise_q[base_r + 2] - rise_q[base_r + 1] == 10 * CPB, "b2b_spacing_2",
          rise_q[base_r + 2] - rise_q[base_r + 1], 10 * CPB);
    end else begin
      chk(1'b0, "b2b_rises", rise_q.size() - base_r, 3);
    end

    // Reset in the middle of data bit 4, released during the stop bit.
    @(posedge clk);
    #1;
    base_s = n_status;
    base_f = n_ferr;
    fork
      send_frame(8'hC3, 1'b1, 0, 1'b0, 1'b0);
      begin
        #(5 * BIT_NS + BIT_NS / 2);
        rst = 1'b1;
        #(4 * BIT_NS);
        rst = 1'b0;
      end
    join
    #(BIT_NS);
    send_frame(8'h81, 1'b1, 0, 1'b1, 1'b1);
    #(2 * BIT_NS);
    @(negedge clk);
    chk(rx_data == 8'h81, "rst_abort_data", rx_data, 8'h81);
    chk(n_status - base_s == 1, "rst_abort_count", n_status - base_s, 1);
    chk(n_ferr == base_f, "rst_abort_ferr", n_ferr, base_f);

    // Random bytes with per-frame bit-time skew up to 2%.
    base_s = n_status;
    base_f = n_ferr;
    for (int i = 0; i < 256; i++) begin
      d    = 8'($urandom_range(255));
      skew = int'($urandom_range(6400)) - 3200;
      gap  = int'($urandom_range(1));
      send_frame(d, 1'b1, skew, 1'b1, 1'b0);
      if (gap != 0) #(BIT_NS + skew / 1000.0);
    end
    #(3 * BIT_NS);
    @(negedge clk);
    chk(n_status - base_s == 256, "loop_count", n_status - base_s, 256);
    chk(n_ferr == base_f, "loop_ferr", n_ferr, base_f);
    chk(exp_q.size() == 0, "all_expected_seen", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
